// File: rtl/ps2_host_tx_ctrl.sv
// ps2_host_tx_ctrl: PS/2 host-to-device command sequencer.
// Inhibit, RTS, 11-bit shift on device clocks, ACK check, response wait.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_hold_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);
  localparam int MAXC = (INHIBIT_CYC > TIMEOUT_CYC) ?
                        INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CW-1:0] INH_END = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INH,
    S_RTS,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [2:0]    r_csync;
  logic [1:0]    r_dsync;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_byte;
  logic          r_par;
  logic [RW-1:0] r_retry;
  logic [3:0]    r_n;
  logic          r_bit;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_code;

  logic       w_fe;
  logic       w_dat;
  logic       w_to;
  logic       w_accept;
  logic       w_retry;
  logic       w_done;
  logic       w_err;
  logic [1:0] w_code;
  logic       w_bit;

  assign w_fe  = r_csync[2] & ~r_csync[1];
  assign w_dat = r_dsync[1];
  assign w_to  = (r_state == S_SHIFT || r_state == S_WAIT) &&
                 (r_cnt == TO_END);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_retry  = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_code   = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          w_next   = S_INH;
        end
      end
      S_INH: begin
        if (r_cnt == INH_END) w_next = S_RTS;
      end
      S_RTS: w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_to) begin
          w_err  = 1'b1;
          w_code = 2'd2;
          w_next = S_IDLE;
        end else if (w_fe && r_n == 4'd10) begin
          if (w_dat) begin
            w_err  = 1'b1;
            w_code = 2'd1;
            w_next = S_IDLE;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_to) begin
          w_err  = 1'b1;
          w_code = 2'd2;
          w_next = S_IDLE;
        end else if (rx_valid_i) begin
          if (rx_data_i == 8'hFA) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else if (rx_data_i == 8'hFE) begin
            if (r_retry < RTY_MAX) begin
              w_retry = 1'b1;
              w_next  = S_INH;
            end else begin
              w_err  = 1'b1;
              w_code = 2'd3;
              w_next = S_IDLE;
            end
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Line value to set up after the current falling edge (bit n = r_n + 1)
  always_comb begin
    w_bit = 1'b0;
    unique case (1'b1)
      (r_n < 4'd8):  w_bit = ~r_byte[r_n[2:0]];
      (r_n == 4'd8): w_bit = ~r_par;
      default:       w_bit = 1'b0;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_csync <= 3'b111;
      r_dsync <= 2'b11;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_par   <= 1'b0;
      r_retry <= '0;
      r_n     <= '0;
      r_bit   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_csync <= {r_csync[1:0], ps2_clk_i};
      r_dsync <= {r_dsync[0], ps2_dat_i};
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_next != r_state || (r_state == S_SHIFT && w_fe))
        r_cnt <= '0;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_byte  <= cmd_data_i;
        r_par   <= ~^cmd_data_i;
        r_retry <= '0;
        r_code  <= 2'd0;
      end
      if (w_retry) r_retry <= r_retry + 1'b1;
      if (w_err)   r_code  <= w_code;
      if (r_state == S_RTS) begin
        r_n   <= '0;
        r_bit <= 1'b1;
      end else if (r_state == S_SHIFT && w_fe && r_n != 4'd10) begin
        r_n   <= r_n + 1'b1;
        r_bit <= w_bit;
      end
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign rx_hold_o    = (r_state != S_IDLE) && (r_state != S_WAIT);
  assign ps2_clk_oe_o = (r_state == S_INH) || (r_state == S_RTS);
  assign ps2_dat_oe_o = (r_state == S_RTS) ||
                        (r_state == S_SHIFT && r_bit && !w_to);
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign err_code_o   = r_code;

endmodule
